// File: rtl/control_unit.sv
// control_unit
// Instruction decode stage for the i16 datapath. Decodes the low three bits of
// the opcode plus the raw immediate field into registered ALU / operand-mux
// controls and a formatted XLEN-bit immediate. Every output comes from a flop,
// so latency is exactly one cycle and there is no input-to-output comb path.
//
// Parameters:
//   L      immediate field width (1..XLEN)
//   OP_L   opcode width (>=3, only Opcode[2:0] is decoded)
//   ALU_W  ALUOpcode width (>=2, upper bits driven 0)
//   XLEN   width of ImmediateOut
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   synchronous active-high reset
//   InstrValid          in   Opcode/Immediate carry a valid instruction
//   Opcode              in   instruction opcode [OP_L]
//   Immediate           in   raw immediate field [L]
//   OutValid            out  decoded outputs are valid
//   LoadUpperImmediate  out  writeback source is the LUI immediate
//   ALUOpcode           out  ALU op: 0 mul, 1 div, 2 pass-B, 3 NOP [ALU_W]
//   UseImmediate        out  ALU operand B comes from ImmediateOut
//   RegWrite            out  register file write enable
//   ImmediateOut        out  formatted immediate [XLEN]
//   Illegal             out  valid reserved opcode decoded
//                            (only when CU_ILLEGAL_DETECT_EN is defined)
//
// Build option: define CU_ILLEGAL_DETECT_EN to add the Illegal output. Without
// it, reserved opcodes decode silently as a valid NOP.

module control_unit #(
  parameter int L     = 5,
  parameter int OP_L  = 3,
  parameter int ALU_W = 2,
  parameter int XLEN  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InstrValid,
  input  logic [OP_L-1:0]   Opcode,
  input  logic [L-1:0]      Immediate,
  output logic              OutValid,
  output logic              LoadUpperImmediate,
  output logic [ALU_W-1:0]  ALUOpcode,
  output logic              UseImmediate,
  output logic              RegWrite,
  output logic [XLEN-1:0]   ImmediateOut
`ifdef CU_ILLEGAL_DETECT_EN
  ,
  output logic              Illegal
`endif
);

  localparam logic [2:0] OP_MUL  = 3'b111;
  localparam logic [2:0] OP_DIV  = 3'b000;
  localparam logic [2:0] OP_MULI = 3'b001;
  localparam logic [2:0] OP_DIVI = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;

  localparam logic [ALU_W-1:0] ALU_MUL  = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_DIV  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_PASS = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_NOP  = ALU_W'(3);

  logic [2:0] op3;
  assign op3 = Opcode[2:0];

  // Immediate formats, computed once and selected by the decoder.
  logic signed [L-1:0] imm_s;
  logic [XLEN-1:0]     imm_sext;
  logic [XLEN-1:0]     imm_lui;

  assign imm_s    = Immediate;
  assign imm_sext = XLEN'(imm_s);
  assign imm_lui  = XLEN'(Immediate) << (XLEN - L);

  logic              valid_d,  valid_q;
  logic              lui_d,    lui_q;
  logic [ALU_W-1:0]  aluop_d,  aluop_q;
  logic              useimm_d, useimm_q;
  logic              regwr_d,  regwr_q;
  logic [XLEN-1:0]   imm_d,    imm_q;
  logic              reserved;

  always_comb begin
    valid_d  = 1'b0;
    lui_d    = 1'b0;
    aluop_d  = ALU_NOP;
    useimm_d = 1'b0;
    regwr_d  = 1'b0;
    imm_d    = '0;
    reserved = 1'b0;

    if (InstrValid) begin
      valid_d = 1'b1;
      unique case (op3)
        OP_MUL: begin
          aluop_d = ALU_MUL;
          regwr_d = 1'b1;
        end
        OP_DIV: begin
          aluop_d = ALU_DIV;
          regwr_d = 1'b1;
        end
        OP_MULI: begin
          aluop_d  = ALU_MUL;
          useimm_d = 1'b1;
          regwr_d  = 1'b1;
          imm_d    = imm_sext;
        end
        OP_DIVI: begin
          aluop_d  = ALU_DIV;
          useimm_d = 1'b1;
          regwr_d  = 1'b1;
          imm_d    = imm_sext;
        end
        OP_LUI: begin
          aluop_d  = ALU_PASS;
          useimm_d = 1'b1;
          lui_d    = 1'b1;
          regwr_d  = 1'b1;
          imm_d    = imm_lui;
        end
        default: begin
          // 100/101/110: valid NOP, nothing written back.
          reserved = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      lui_q    <= 1'b0;
      aluop_q  <= ALU_NOP;
      useimm_q <= 1'b0;
      regwr_q  <= 1'b0;
      imm_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      lui_q    <= lui_d;
      aluop_q  <= aluop_d;
      useimm_q <= useimm_d;
      regwr_q  <= regwr_d;
      imm_q    <= imm_d;
    end
  end

  assign OutValid           = valid_q;
  assign LoadUpperImmediate = lui_q;
  assign ALUOpcode          = aluop_q;
  assign UseImmediate       = useimm_q;
  assign RegWrite           = regwr_q;
  assign ImmediateOut       = imm_q;

`ifdef CU_ILLEGAL_DETECT_EN
  logic illegal_d, illegal_q;

  assign illegal_d = reserved;

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign Illegal = illegal_q;
`else
  // Reserved opcodes still produce the NOP decode above; the flag is unused.
  logic unused_reserved;
  assign unused_reserved = reserved;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        InstrValid;
  logic [2:0]  Opcode;
  logic [4:0]  Immediate;
  logic        OutValid;
  logic        LoadUpperImmediate;
  logic [1:0]  ALUOpcode;
  logic        UseImmediate;
  logic        RegWrite;
  logic [15:0] ImmediateOut;
`ifdef CU_ILLEGAL_DETECT_EN
  logic        Illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_unit #(.L(5), .OP_L(3), .ALU_W(2), .XLEN(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .InstrValid         (InstrValid),
    .Opcode             (Opcode),
    .Immediate          (Immediate),
    .OutValid           (OutValid),
    .LoadUpperImmediate (LoadUpperImmediate),
    .ALUOpcode          (ALUOpcode),
    .UseImmediate       (UseImmediate),
    .RegWrite           (RegWrite),
    .ImmediateOut       (ImmediateOut)
`ifdef CU_ILLEGAL_DETECT_EN
    ,
    .Illegal            (Illegal)
`endif
  );

  // Packed view {OutValid, LUI, ALUOpcode, UseImm, RegWrite, ImmediateOut}.
  logic [21:0] obs;
  assign obs = {OutValid, LoadUpperImmediate, ALUOpcode, UseImmediate, RegWrite, ImmediateOut};

  localparam logic [21:0] EXP_NOP_INVALID = {1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0000};
  localparam logic [21:0] EXP_NOP_VALID   = {1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0000};
  localparam logic [21:0] EXP_MUL         = {1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000};
  localparam logic [21:0] EXP_DIV         = {1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000};

  // Drive inputs just after an edge, let the next edge sample them, look 1 ns later.
  task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [4:0] imm);
    rst        = r;
    InstrValid = v;
    Opcode     = op;
    Immediate  = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'b000, 5'b0);
    step(1'b1, 1'b0, 3'b000, 5'b0);
    checks++;
    if (obs !== EXP_NOP_INVALID) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, EXP_NOP_INVALID);
    end
`ifdef CU_ILLEGAL_DETECT_EN
    checks++;
    if (Illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal: got %b expected 0", Illegal);
    end
`endif
    step(1'b1, 1'b1, 3'b111, 5'b10101);
    checks++;
    if (obs !== EXP_NOP_INVALID) begin
      errors++;
      $display("FAIL reset_drops_instr: got %h expected %h", obs, EXP_NOP_INVALID);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, 3'b111, 5'b11111);
    checks++;
    if (obs !== EXP_MUL) begin
      errors++;
      $display("FAIL b2b_mul: got %h expected %h", obs, EXP_MUL);
    end
    step(1'b0, 1'b1, 3'b000, 5'b01010);
    checks++;
    if (obs !== EXP_DIV) begin
      errors++;
      $display("FAIL b2b_div: got %h expected %h", obs, EXP_DIV);
    end
  endtask

  task automatic test_imm_ops();
    logic [21:0] exp;
    step(1'b0, 1'b1, 3'b001, 5'b10011);
    exp = {1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 16'hFFF3};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL muli_neg: got %h expected %h", obs, exp);
    end
    step(1'b0, 1'b1, 3'b001, 5'b01111);
    exp = {1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 16'h000F};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL muli_maxpos: got %h expected %h", obs, exp);
    end
    step(1'b0, 1'b1, 3'b010, 5'b00101);
    exp = {1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 16'h0005};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL divi_pos: got %h expected %h", obs, exp);
    end
    step(1'b0, 1'b1, 3'b010, 5'b10000);
    exp = {1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 16'hFFF0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL divi_minneg: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_lui();
    logic [21:0] exp;
    step(1'b0, 1'b1, 3'b011, 5'b10101);
    exp = {1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 16'hA800};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL lui_a800: got %h expected %h", obs, exp);
    end
    step(1'b0, 1'b1, 3'b011, 5'b11111);
    exp = {1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 16'hF800};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL lui_f800: got %h expected %h", obs, exp);
    end
    step(1'b0, 1'b1, 3'b011, 5'b00001);
    exp = {1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 16'h0800};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL lui_0800: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reserved();
    logic [2:0] ops [3] = '{3'b100, 3'b101, 3'b110};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, ops[i], 5'b10101);
      checks++;
      if (obs !== EXP_NOP_VALID) begin
        errors++;
        $display("FAIL reserved_%b: got %h expected %h", ops[i], obs, EXP_NOP_VALID);
      end
`ifdef CU_ILLEGAL_DETECT_EN
      checks++;
      if (Illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal_%b: got %b expected 1", ops[i], Illegal);
      end
`endif
    end
    step(1'b0, 1'b0, 3'b101, 5'b11111);
    checks++;
    if (obs !== EXP_NOP_INVALID) begin
      errors++;
      $display("FAIL invalid_after_reserved: got %h expected %h", obs, EXP_NOP_INVALID);
    end
`ifdef CU_ILLEGAL_DETECT_EN
    checks++;
    if (Illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clears: got %b expected 0", Illegal);
    end
`endif
  endtask

  task automatic test_invalid_masks();
    step(1'b0, 1'b0, 3'b011, 5'b11111);
    checks++;
    if (obs !== EXP_NOP_INVALID) begin
      errors++;
      $display("FAIL invalid_lui: got %h expected %h", obs, EXP_NOP_INVALID);
    end
    step(1'b0, 1'b1, 3'b111, 5'b11111);
    checks++;
    if (obs !== EXP_MUL) begin
      errors++;
      $display("FAIL mul_imm_zero: got %h expected %h", obs, EXP_MUL);
    end
  endtask

  task automatic test_midstream_reset();
    logic [21:0] exp;
    step(1'b0, 1'b1, 3'b000, 5'b0);
    step(1'b1, 1'b1, 3'b010, 5'b00101);
    checks++;
    if (obs !== EXP_NOP_INVALID) begin
      errors++;
      $display("FAIL midstream_reset: got %h expected %h", obs, EXP_NOP_INVALID);
    end
    step(1'b0, 1'b1, 3'b010, 5'b00101);
    exp = {1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 16'h0005};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL resume_after_reset: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    InstrValid = 1'b0;
    Opcode     = 3'b000;
    Immediate  = 5'b0;
    #1;
    test_reset();
    test_back_to_back();
    test_imm_ops();
    test_lui();
    test_reserved();
    test_invalid_masks();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
